// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: BRESP codes, default AWPROT and the write-manager state set.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access.
  localparam logic [2:0] AWPROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_SEND,
    ST_WAIT_B,
    ST_REPORT
  } wr_state_e;

endpackage

// File: rtl/axi_lite_watchdog.sv
// Saturating cycle counter with clear/enable and a sticky expired flag.
module axi_lite_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // expired rises on the same edge the count saturates.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
      if (count == (CNT_MAX - CNT_W'(1))) begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_write_initiator.sv
// AXI4-Lite write manager: one outstanding single-word write, BRESP returned over a valid/ready port.
module axi_lite_write_initiator
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE   = 32,
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDRESS_SIZE-1:0]   cmd_address,
  input  logic [DATA_SIZE-1:0]      cmd_data,
  input  logic [DATA_SIZE/8-1:0]    cmd_strobe,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic [1:0]                rsp_code,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      timeout_flag,
  output logic [ADDRESS_SIZE-1:0]   m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_SIZE-1:0]      m_wdata,
  output logic [DATA_SIZE/8-1:0]    m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready
);

  localparam int unsigned STRB_SIZE = DATA_SIZE / 8;

  wr_state_e                 state_q, state_d;
  logic                      aw_done, aw_done_d;
  logic                      w_done, w_done_d;
  logic                      cmd_ready_d;
  logic [1:0]                rsp_code_d;
  logic                      rsp_valid_d;
  logic [ADDRESS_SIZE-1:0]   m_awaddr_d;
  logic                      m_awvalid_d;
  logic [DATA_SIZE-1:0]      m_wdata_d;
  logic [STRB_SIZE-1:0]      m_wstrb_d;
  logic                      m_wvalid_d;
  logic                      m_bready_d;

  logic cmd_accept, aw_hs, w_hs, b_hs, rsp_hs;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign aw_hs      = m_awvalid && m_awready;
  assign w_hs       = m_wvalid && m_wready;
  assign b_hs       = m_bvalid && m_bready;
  assign rsp_hs     = rsp_valid && rsp_ready;
  assign m_awprot   = AWPROT_DEFAULT;

  // State and all output registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_RESET;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_code  <= 2'b00;
      rsp_valid <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done   <= aw_done_d;
      w_done    <= w_done_d;
      cmd_ready <= cmd_ready_d;
      rsp_code  <= rsp_code_d;
      rsp_valid <= rsp_valid_d;
      m_awaddr  <= m_awaddr_d;
      m_awvalid <= m_awvalid_d;
      m_wdata   <= m_wdata_d;
      m_wstrb   <= m_wstrb_d;
      m_wvalid  <= m_wvalid_d;
      m_bready  <= m_bready_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a handshake moves it.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done;
    w_done_d    = w_done;
    cmd_ready_d = cmd_ready;
    rsp_code_d  = rsp_code;
    rsp_valid_d = rsp_valid;
    m_awaddr_d  = m_awaddr;
    m_awvalid_d = m_awvalid;
    m_wdata_d   = m_wdata;
    m_wstrb_d   = m_wstrb;
    m_wvalid_d  = m_wvalid;
    m_bready_d  = m_bready;

    unique case (state_q)
      ST_RESET: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_accept) begin
          m_awaddr_d  = cmd_address;
          m_wdata_d   = cmd_data;
          m_wstrb_d   = cmd_strobe;
          cmd_ready_d = 1'b0;
          m_awvalid_d = 1'b1;
          m_wvalid_d  = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (aw_hs) begin
          m_awvalid_d = 1'b0;
          aw_done_d   = 1'b1;
        end
        if (w_hs) begin
          m_wvalid_d = 1'b0;
          w_done_d   = 1'b1;
        end
        // Either channel may finish first or both on the same edge.
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          m_bready_d = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (b_hs) begin
          rsp_code_d  = m_bresp;
          m_bready_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Stalls are only flagged; valid is never withdrawn.
  axi_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (cmd_accept),
    .enable  ((state_q == ST_SEND) || (state_q == ST_WAIT_B)),
    .expired (timeout_flag)
  );

endmodule

// File: doc/axi_lite_write_initiator.md
Name: axi_lite_write_initiator

Overview:
AXI4-Lite write manager (initiator). It takes single-word write commands from local logic over a valid/ready command port and drives the AW, W and B channels toward an AXI4-Lite subordinate. It returns each BRESP to the local logic over a valid/ready response port. Only one transaction is outstanding at a time, and a watchdog flags subordinates that stall.

Parameters:
ADDRESS_SIZE, 32, width of cmd_address and m_awaddr
DATA_SIZE, 32, width of cmd_data and m_wdata; must be 32 or 64
TIMEOUT_CYCLES, 1024, cycles from command accept to B handshake before timeout_flag asserts; minimum 2

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
cmd_address  in  ADDRESS_SIZE  target byte address
cmd_data  in  DATA_SIZE  write data
cmd_strobe  in  DATA_SIZE/8  byte enables
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
rsp_code  out  2  captured BRESP
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
timeout_flag  out  1  sticky: current/last transaction exceeded TIMEOUT_CYCLES
m_awaddr  out  ADDRESS_SIZE  AW address
m_awprot  out  3  constant 3'b000
m_awvalid  out  1
m_awready  in  1
m_wdata  out  DATA_SIZE
m_wstrb  out  DATA_SIZE/8
m_wvalid  out  1
m_wready  in  1
m_bresp  in  2
m_bvalid  in  1
m_bready  out  1

Behaviour:
- Clock and reset: aclk rising edge; aresetn synchronous, active-low.
- All outputs are registered.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_code=0, timeout_flag=0, m_awvalid=0, m_wvalid=0, m_bready=0, m_awaddr=0, m_wdata=0, m_wstrb=0. State = RESET.
- RESET state: lasts 1 cycle after aresetn deasserts, sets cmd_ready=1, then goes to IDLE.
- IDLE:
  - On cmd_valid && cmd_ready: latch address, data and strobe into the m_aw*/m_w* registers.
  - Same edge: cmd_ready<=0, m_awvalid<=1, m_wvalid<=1, timeout_flag<=0, watchdog counter<=0, state<=SEND.
  - AW and W are therefore valid exactly 1 cycle after command accept.
- SEND:
  - aw_done/w_done flags track each channel independently.
  - On m_awvalid && m_awready: m_awvalid<=0, aw_done<=1.
  - On m_wvalid && m_wready: m_wvalid<=0, w_done<=1.
  - The two handshakes may complete in either order or on the same cycle.
  - Once both are done (counting handshakes on the current edge): m_bready<=1, clear done flags, state<=WAIT_B.
  - Valid, once asserted, is never dropped before its handshake. Address, data and strobe stay stable while valid is high.
- WAIT_B:
  - On m_bvalid && m_bready: rsp_code<=m_bresp, m_bready<=0, rsp_valid<=1, state<=REPORT.
  - An m_bvalid seen before WAIT_B is ignored, because m_bready is 0.
- REPORT:
  - Hold rsp_valid and rsp_code stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid<=0, cmd_ready<=1, state<=IDLE.
  - Minimum command-to-command spacing is therefore 4 cycles with zero-wait subordinate and consumer.
- Watchdog:
  - Counter of width clog2(TIMEOUT_CYCLES+1). It increments every cycle in SEND and WAIT_B and saturates at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES, timeout_flag<=1. The flag is sticky until the next command accept.
  - The transaction is never aborted; AXI rules forbid withdrawing valid.
- BRESP handling: passed through unmodified (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR). There is no retry.
- Reset mid-operation: any state returns to RESET on the next edge and all outputs take their reset values. The in-flight transaction is dropped. The subordinate shares aresetn.
- No combinational path from any input to any output.

Decomposition:
- Shared package axi_lite_pkg:
  - BRESP localparams: RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR.
  - State enum for this block: RESET, IDLE, SEND, WAIT_B, REPORT.
  - AWPROT default constant.
- The write subordinate uses the same BRESP constants.
- Optional sub-module axi_lite_watchdog: saturating counter with clear, enable and sticky-expired flag, reusable by the read-side manager.

Test Plan:
1. Zero-wait subordinate (awready=wready=1, bvalid 1 cycle after bready), cmd 0x0000_0010/0xDEAD_BEEF/4'hF:
   - AW and W handshake on cycle 1 after accept.
   - bready high on cycle 2.
   - rsp_valid=1, rsp_code=2'b00 one cycle after the B handshake.
   - cmd_ready returns 1 after rsp_ready.
2. Skewed channels: wready immediate, awready delayed 3 cycles:
   - m_wvalid drops after 1 cycle.
   - m_awvalid held 4 cycles with m_awaddr stable.
   - Swapped skew gives the symmetric result.
   - bready rises only after both handshakes.
3. Subordinate returns bresp=2'b10 for address 0x0000_0004 -> rsp_code=2'b10, timeout_flag=0.
4. rsp_ready held low 6 cycles with a second cmd_valid pending:
   - rsp_valid/rsp_code stable throughout.
   - cmd_ready stays 0.
   - The second command is accepted only after the response handshake.
5. TIMEOUT_CYCLES=8, bvalid withheld 20 cycles:
   - timeout_flag=1 after 8 cycles in SEND+WAIT_B; bready stays high.
   - The late B completes normally.
   - The flag clears at the next command accept.
6. aresetn low for 1 cycle during WAIT_B:
   - All valids, bready and rsp_valid are 0 next cycle.
   - cmd_ready=1 one cycle after reset release.
   - A new command completes normally.
